// File: rtl/uart_row_writer.sv
// uart_row_writer: latches one received pixel row on the rising edge of the
// receiver's done and streams it, one pixel per beat, into the frame-buffer
// write port under valid/ready flow control.
module uart_row_writer #(
  parameter int Wight  = 640,
  parameter int Height = 480,
  parameter int PIX_W  = 3,
  parameter int ADDR_W = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8:0]               row_in,
  input  logic [PIX_W*Wight-1:0]   data_in,
  input  logic                     done_in,
  output logic                     fb_we,
  input  logic                     fb_ready,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [PIX_W-1:0]         fb_wdata,
  output logic                     busy,
  output logic                     row_written,
  output logic                     frame_done,
  output logic                     row_err,
  output logic                     overflow
);

  localparam int                XW       = $clog2(Wight);
  localparam logic [XW-1:0]     X_LAST   = XW'(Wight - 1);
  localparam logic [8:0]        ROW_LAST = 9'(Height - 1);
  localparam logic [ADDR_W-1:0] WIGHT_A  = ADDR_W'(Wight);

  typedef enum logic [1:0] {IDLE, BASE, WRITE, DONE} state_t;

  state_t                   state;
  logic                     done_d;
  logic                     start;
  logic [8:0]               row_p0;
  logic [PIX_W*Wight-1:0]   shadow_p0;
  logic [ADDR_W-1:0]        base_p1;
  logic [XW-1:0]            x;
  logic [XW-1:0]            x_next;

  // Only a rising edge of done starts a row; a held-high done is ignored.
  assign start  = done_in && !done_d;
  assign x_next = x + XW'(1);

  function automatic logic [PIX_W-1:0] pix_at(input logic [PIX_W*Wight-1:0] row,
                                              input logic [XW-1:0]          idx);
    return row[PIX_W*idx +: PIX_W];
  endfunction

  // Row capture (stage 0) and base address (stage 1); data only, no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && row_in <= ROW_LAST) begin
      row_p0    <= row_in;
      shadow_p0 <= data_in;
    end
    if (state == BASE) begin
      base_p1 <= ADDR_W'(row_p0) * WIGHT_A;
    end
  end

  // Control FSM with registered beat outputs and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done_d      <= 1'b0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
      x           <= '0;
      busy        <= 1'b0;
      row_written <= 1'b0;
      frame_done  <= 1'b0;
      row_err     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done_d      <= done_in;
      row_written <= 1'b0;
      frame_done  <= 1'b0;
      row_err     <= 1'b0;
      overflow    <= 1'b0;
      // A new row arriving while one is in flight is dropped, not queued.
      if (start && state != IDLE) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (row_in > ROW_LAST) begin
              row_err <= 1'b1;
            end else begin
              state <= BASE;
              busy  <= 1'b1;
            end
          end
        end
        BASE: begin
          state    <= WRITE;
          x        <= '0;
          fb_we    <= 1'b1;
          fb_addr  <= ADDR_W'(row_p0) * WIGHT_A;
          fb_wdata <= pix_at(shadow_p0, '0);
        end
        WRITE: begin
          // Without fb_ready everything holds, so no beat is lost or repeated.
          if (fb_ready) begin
            if (x == X_LAST) begin
              state       <= DONE;
              fb_we       <= 1'b0;
              row_written <= 1'b1;
              frame_done  <= (row_p0 == ROW_LAST);
            end else begin
              x        <= x_next;
              fb_addr  <= base_p1 + ADDR_W'(x_next);
              fb_wdata <= pix_at(shadow_p0, x_next);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          fb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_row_writer.sv
// Testbench for uart_row_writer: random pixel rows streamed through the DUT,
// every accepted beat checked against a row/pixel reference model.
module tb_uart_row_writer;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int P  = 3;
  localparam int AW = 19;
  localparam int RW = P * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [8:0]    row_in = '0;
  logic [RW-1:0] data_in = '0;
  logic          done_in = 1'b0;
  logic          fb_ready = 1'b1;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [P-1:0]  fb_wdata;
  logic          busy, row_written, frame_done, row_err, overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_row_writer #(.Wight(W), .Height(H), .PIX_W(P), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .data_in(data_in), .done_in(done_in),
    .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .row_written(row_written), .frame_done(frame_done),
    .row_err(row_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic, recorded mid-cycle.
  logic [AW-1:0] q_addr[$];
  logic [P-1:0]  q_data[$];
  int rw_cnt, fd_cnt, err_cnt, ovf_cnt, busy_cnt, stall_viol;
  int first_we_cyc, last_acc_cyc, rw_cyc, fd_cyc;
  logic          prev_stall;
  logic [AW-1:0] p_addr;
  logic [P-1:0]  p_data;

  always @(negedge clk) begin
    if (prev_stall && !(fb_we && fb_addr == p_addr && fb_wdata == p_data)) stall_viol++;
    prev_stall = fb_we && !fb_ready;
    p_addr = fb_addr;
    p_data = fb_wdata;
    if (fb_we && first_we_cyc < 0) first_we_cyc = cyc;
    if (fb_we && fb_ready) begin
      q_addr.push_back(fb_addr);
      q_data.push_back(fb_wdata);
      last_acc_cyc = cyc;
    end
    if (row_written) begin rw_cnt++; rw_cyc = cyc; end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (row_err) err_cnt++;
    if (overflow) ovf_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    rw_cnt = 0; fd_cnt = 0; err_cnt = 0; ovf_cnt = 0; busy_cnt = 0; stall_viol = 0;
    first_we_cyc = -1; last_acc_cyc = -1; rw_cyc = -1; fd_cyc = -1;
    prev_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] v;
    for (int i = 0; i < RW; i += 32) v[i +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: row r, pixel i must appear as beat off+i with address
  // r*W+i and the i-th pixel of the row. Returns first bad beat or -1.
  function automatic int first_bad(input int r, input logic [RW-1:0] d, input int off);
    for (int i = 0; i < W; i++) begin
      if (off + i >= q_addr.size()) return i;
      if (q_addr[off+i] !== AW'(r * W + i)) return i;
      if (q_data[off+i] !== d[P*i +: P]) return i;
    end
    return -1;
  endfunction

  task automatic pulse_done(input int r, input logic [RW-1:0] d, input int hold);
    row_in  = 9'(r);
    data_in = d;
    done_in = 1'b1;
    repeat (hold) step();
    done_in = 1'b0;
  endtask

  task automatic wait_rw(input int n, input int budget, output bit to);
    to = 1'b0;
    for (int i = 0; i < budget && rw_cnt < n; i++) step();
    if (rw_cnt < n) to = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit to);
    to = 1'b0;
    for (int i = 0; i < budget && q_addr.size() < n; i++) step();
    if (q_addr.size() < n) to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    done_in = 1'b0;
    clear_mon();
    repeat (3) step();
    total++;
    if ({fb_we, busy, row_written, frame_done, row_err, overflow} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {fb_we, busy, row_written, frame_done, row_err, overflow});
    end
    total++;
    if (fb_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", fb_addr); end
    total++;
    if (fb_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%0d want=0", fb_wdata); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_basic_row();
    logic [RW-1:0] d;
    int s, fb;
    bit to;
    for (int i = 0; i < W; i++) d[P*i +: P] = P'(i % 8);
    clear_mon();
    s = cyc;
    pulse_done(5, d, 1);
    wait_rw(1, 2000, to);
    repeat (5) step();
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=%0d want=1 rows", rw_cnt); end
    fb = first_bad(5, d, 0);
    total++;
    if (fb !== -1) begin bad++; $display("FAIL basic_beats got=bad beat %0d want=-1", fb); end
    total++;
    if (q_addr.size() !== W) begin bad++; $display("FAIL basic_count got=%0d want=%0d", q_addr.size(), W); end
    total++;
    if (first_we_cyc !== s + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", first_we_cyc, s + 2); end
    total++;
    if (last_acc_cyc !== s + 2 + W - 1) begin
      bad++; $display("FAIL basic_consecutive got=%0d want=%0d", last_acc_cyc, s + 2 + W - 1);
    end
    total++;
    if (rw_cyc !== s + 2 + W) begin bad++; $display("FAIL basic_rw_time got=%0d want=%0d", rw_cyc, s + 2 + W); end
    total++;
    if (fd_cnt !== 0 || rw_cnt !== 1) begin
      bad++; $display("FAIL basic_pulses got=rw%0d fd%0d want=rw1 fd0", rw_cnt, fd_cnt);
    end
  endtask

  task automatic test_last_row();
    logic [RW-1:0] d;
    logic [AW-1:0] last;
    int fb;
    bit to;
    d = rand_row();
    clear_mon();
    pulse_done(H - 1, d, 1);
    wait_rw(1, 2000, to);
    repeat (5) step();
    fb = first_bad(H - 1, d, 0);
    total++;
    if (to || fb !== -1) begin bad++; $display("FAIL last_beats got=bad beat %0d want=-1", fb); end
    last = (q_addr.size() > 0) ? q_addr[q_addr.size()-1] : '0;
    total++;
    if (last !== AW'(W * H - 1)) begin bad++; $display("FAIL last_addr got=%0d want=%0d", last, W * H - 1); end
    total++;
    if (fd_cnt !== 1 || fd_cyc !== rw_cyc) begin
      bad++; $display("FAIL last_frame_done got=cnt%0d cyc%0d want=cnt1 cyc%0d", fd_cnt, fd_cyc, rw_cyc);
    end
  endtask

  task automatic test_stall();
    logic [RW-1:0] d;
    int fb;
    d = rand_row();
    clear_mon();
    pulse_done(10, d, 1);
    for (int i = 0; i < 4000 && rw_cnt < 1; i++) begin
      fb_ready = ~fb_ready;
      step();
    end
    fb_ready = 1'b1;
    repeat (5) step();
    fb = first_bad(10, d, 0);
    total++;
    if (fb !== -1) begin bad++; $display("FAIL stall_beats got=bad beat %0d want=-1", fb); end
    total++;
    if (q_addr.size() !== W) begin bad++; $display("FAIL stall_count got=%0d want=%0d", q_addr.size(), W); end
    total++;
    if (stall_viol !== 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_viol); end
  endtask

  task automatic test_held_done();
    logic [RW-1:0] d;
    int r, fb;
    bit to;
    d = rand_row();
    r = $urandom_range(H - 2, 0);
    clear_mon();
    pulse_done(r, d, 20);
    wait_rw(1, 2000, to);
    repeat (30) step();
    fb = first_bad(r, d, 0);
    total++;
    if (to || fb !== -1) begin bad++; $display("FAIL held_beats got=bad beat %0d want=-1", fb); end
    total++;
    if (q_addr.size() !== W || rw_cnt !== 1 || ovf_cnt !== 0) begin
      bad++; $display("FAIL held_once got=beats%0d rows%0d ovf%0d want=beats%0d rows1 ovf0",
                      q_addr.size(), rw_cnt, ovf_cnt, W);
    end
  endtask

  task automatic test_overflow();
    logic [RW-1:0] d1, d2;
    int fb;
    bit to;
    d1 = rand_row();
    d2 = ~d1;
    clear_mon();
    pulse_done(7, d1, 1);
    wait_beats(100, 2000, to);
    pulse_done(9, d2, 1);
    wait_rw(1, 2000, to);
    repeat (20) step();
    total++;
    if (ovf_cnt !== 1) begin bad++; $display("FAIL ovf_pulse got=%0d want=1", ovf_cnt); end
    fb = first_bad(7, d1, 0);
    total++;
    if (to || fb !== -1) begin bad++; $display("FAIL ovf_intact got=bad beat %0d want=-1", fb); end
    total++;
    if (q_addr.size() !== W || rw_cnt !== 1) begin
      bad++; $display("FAIL ovf_no_second got=beats%0d rows%0d want=beats%0d rows1", q_addr.size(), rw_cnt, W);
    end
  endtask

  task automatic test_row_err();
    int rows[2];
    rows[0] = H;
    rows[1] = $urandom_range(511, H + 1);
    foreach (rows[k]) begin
      clear_mon();
      pulse_done(rows[k], rand_row(), 1);
      repeat (10) step();
      total++;
      if (err_cnt !== 1) begin bad++; $display("FAIL err_pulse row%0d got=%0d want=1", rows[k], err_cnt); end
      total++;
      if (q_addr.size() !== 0 || busy_cnt !== 0) begin
        bad++; $display("FAIL err_quiet row%0d got=beats%0d busy%0d want=0 0", rows[k], q_addr.size(), busy_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] d;
    int fb;
    bit to;
    clear_mon();
    pulse_done(3, rand_row(), 1);
    wait_beats(300, 2000, to);
    rst = 1'b1;
    step();
    total++;
    if (fb_we !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs got=we%0b busy%0b want=0 0", fb_we, busy);
    end
    rst = 1'b0;
    repeat (700) step();
    total++;
    if (rw_cnt !== 0) begin bad++; $display("FAIL rstmid_no_row got=%0d want=0", rw_cnt); end
    d = rand_row();
    clear_mon();
    pulse_done(2, d, 1);
    wait_rw(1, 2000, to);
    repeat (5) step();
    fb = first_bad(2, d, 0);
    total++;
    if (to || fb !== -1 || q_addr.size() !== W) begin
      bad++; $display("FAIL rstmid_fresh got=bad beat %0d count %0d want=-1 %0d", fb, q_addr.size(), W);
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] d1, d2;
    int r1, r2, f1, f2;
    bit to;
    d1 = rand_row();
    d2 = rand_row();
    r1 = $urandom_range(H - 1, 0);
    r2 = $urandom_range(H - 1, 0);
    clear_mon();
    pulse_done(r1, d1, 1);
    wait_rw(1, 2000, to);
    pulse_done(r2, d2, 1);
    wait_rw(2, 2000, to);
    repeat (5) step();
    f1 = first_bad(r1, d1, 0);
    f2 = first_bad(r2, d2, W);
    total++;
    if (to || f1 !== -1 || f2 !== -1) begin
      bad++; $display("FAIL b2b_beats got=%0d %0d want=-1 -1", f1, f2);
    end
    total++;
    if (ovf_cnt !== 0 || rw_cnt !== 2 || q_addr.size() !== 2 * W) begin
      bad++; $display("FAIL b2b_accept got=ovf%0d rows%0d beats%0d want=0 2 %0d", ovf_cnt, rw_cnt, q_addr.size(), 2 * W);
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] d;
    int r, fb;
    bit to;
    for (int n = 0; n < 4; n++) begin
      d = rand_row();
      r = (n == 3) ? H - 1 : $urandom_range(H - 1, 0);
      clear_mon();
      row_in  = 9'(r);
      data_in = d;
      done_in = 1'b1;
      for (int i = 0; i < 4000 && rw_cnt < 1; i++) begin
        if (i >= int'($urandom_range(5, 1))) done_in = 1'b0;
        fb_ready = ($urandom_range(3, 0) != 0);
        step();
      end
      done_in  = 1'b0;
      fb_ready = 1'b1;
      repeat (5) step();
      fb = first_bad(r, d, 0);
      total++;
      if (fb !== -1 || q_addr.size() !== W) begin
        bad++; $display("FAIL rand_beats row%0d got=bad beat %0d count %0d want=-1 %0d", r, fb, q_addr.size(), W);
      end
      total++;
      if (rw_cnt !== 1 || fd_cnt !== int'(r == H - 1) || stall_viol !== 0) begin
        bad++; $display("FAIL rand_status row%0d got=rw%0d fd%0d stall%0d want=1 %0d 0",
                        r, rw_cnt, fd_cnt, stall_viol, int'(r == H - 1));
      end
    end
  endtask

  task automatic test_reset_done_high();
    logic [RW-1:0] d;
    int fb;
    bit to;
    d = rand_row();
    clear_mon();
    row_in  = 9'd100;
    data_in = d;
    done_in = 1'b1;
    rst     = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    done_in = 1'b0;
    wait_rw(1, 2000, to);
    repeat (5) step();
    fb = first_bad(100, d, 0);
    total++;
    if (to || fb !== -1 || rw_cnt !== 1) begin
      bad++; $display("FAIL rst_done_high got=bad beat %0d rows %0d want=-1 1", fb, rw_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_last_row();
    test_stall();
    test_held_done();
    test_overflow();
    test_row_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_reset_done_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
